// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Brief    : Shared constants for the PS/2 read sequencer and scan-code parser
//  Revision : 1.0  initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    localparam logic [1:0] RD_IDLE     = 2'd0;
    localparam logic [1:0] RD_ACK      = 2'd1;
    localparam logic [1:0] RD_SETTLE   = 2'd2;

    localparam logic [1:0] PS_NORM     = 2'd0;
    localparam logic [1:0] PS_EXT      = 2'd1;
    localparam logic [1:0] PS_BRK      = 2'd2;
    localparam logic [1:0] PS_EXTBRK   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ps2_fifo_rd.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_fifo_rd
//  Brief    : Pops one byte from the keyboard FIFO per IDLE->ACK->SETTLE pass
//  Revision : 1.0  initial release
// ============================================================================
module ps2_fifo_rd (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ready,
    input  logic [7:0] data,
    output logic       nextdata_n,
    output logic [7:0] byte_r,
    output logic       byte_stb
);
    import ps2_pkg::*;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_capture;
    logic       r_nextdata_n;
    logic [7:0] r_byte;
    logic       r_byte_stb;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_state <= RD_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RD_IDLE:   if (ready) w_state_nxt = RD_ACK;
            RD_ACK:    w_state_nxt = RD_SETTLE;
            RD_SETTLE: w_state_nxt = RD_IDLE;
            default:   w_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        w_capture = (r_state == RD_IDLE) && ready;
    end

    // Strobe spans exactly the ACK cycle, so the parser advances on the edge leaving ACK.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_nextdata_n <= 1'b1;
            r_byte_stb   <= 1'b0;
            r_byte       <= 8'h00;
        end else begin
            r_nextdata_n <= ~w_capture;
            r_byte_stb   <= w_capture;
            if (w_capture) r_byte <= data;
        end
    end

    assign nextdata_n = r_nextdata_n;
    assign byte_r     = r_byte;
    assign byte_stb   = r_byte_stb;

endmodule
`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_ctrl
//  Brief    : Drains the PS/2 scan FIFO and parses set-2 make/break/E0 events
//  Revision : 1.0  initial release
// ============================================================================
module ps2_key_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    input  logic             clr_err,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic             key_valid,
    output logic             key_repeat,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err
);
    import ps2_pkg::*;

    logic [7:0]       w_byte;
    logic             w_byte_stb;
    logic [1:0]       r_ps;
    logic [1:0]       w_ps_nxt;
    logic             w_is_pfx;
    logic             w_make;
    logic             w_brk;
    logic             w_ext;
    logic             w_repeat;
    logic [7:0]       r_key_code;
    logic             r_key_ext;
    logic             r_key_down;
    logic             r_key_valid;
    logic             r_key_repeat;
    logic [CNT_W-1:0] r_press_cnt;
    logic             r_err;

    ps2_fifo_rd u_fifo_rd (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .data       (data),
        .nextdata_n (nextdata_n),
        .byte_r     (w_byte),
        .byte_stb   (w_byte_stb)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_ps <= PS_NORM;
        else       r_ps <= w_ps_nxt;
    end

    always_comb begin
        w_ps_nxt = r_ps;
        if (w_byte_stb) begin
            case (r_ps)
                PS_NORM:   if (w_byte == PS2_PFX_EXT)      w_ps_nxt = PS_EXT;
                           else if (w_byte == PS2_PFX_BRK) w_ps_nxt = PS_BRK;
                PS_EXT:    if (w_byte == PS2_PFX_BRK)      w_ps_nxt = PS_EXTBRK;
                           else if (w_byte != PS2_PFX_EXT) w_ps_nxt = PS_NORM;
                default:   if (!w_is_pfx)                  w_ps_nxt = PS_NORM;
            endcase
        end
    end

    // Prefix bytes inside a break sequence are swallowed; only a code byte closes it.
    always_comb begin
        w_is_pfx = (w_byte == PS2_PFX_EXT) || (w_byte == PS2_PFX_BRK);
        w_make   = 1'b0;
        w_brk    = 1'b0;
        w_ext    = (r_ps == PS_EXT) || (r_ps == PS_EXTBRK);
        case (r_ps)
            PS_NORM, PS_EXT: w_make = w_byte_stb && !w_is_pfx;
            default:         w_brk  = w_byte_stb && !w_is_pfx;
        endcase
        w_repeat = w_make && r_key_down && (r_key_code == w_byte) && (r_key_ext == w_ext);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_key_code   <= 8'h00;
            r_key_ext    <= 1'b0;
            r_key_down   <= 1'b0;
            r_key_valid  <= 1'b0;
            r_key_repeat <= 1'b0;
            r_press_cnt  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_key_valid  <= w_make || w_brk;
            r_key_repeat <= w_repeat;
            if (w_make || w_brk) begin
                r_key_code <= w_byte;
                r_key_ext  <= w_ext;
                r_key_down <= w_make;
            end
            if (w_make && !w_repeat)
                r_press_cnt <= r_press_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (overflow)     r_err <= 1'b1;
            else if (clr_err) r_err <= 1'b0;
        end
    end

    assign key_code   = r_key_code;
    assign key_ext    = r_key_ext;
    assign key_down   = r_key_down;
    assign key_valid  = r_key_valid;
    assign key_repeat = r_key_repeat;
    assign press_cnt  = r_press_cnt;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_ctrl
//  Brief    : Directed bench for ps2_key_ctrl with a behavioural keyboard FIFO
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       overflow = 1'b0;
    logic       clr_err = 1'b0;
    logic       nextdata_n;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_down;
    logic       key_valid;
    logic       key_repeat;
    logic [7:0] press_cnt;
    logic       err;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.CNT_W(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .data       (data),
        .overflow   (overflow),
        .clr_err    (clr_err),
        .nextdata_n (nextdata_n),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_down   (key_down),
        .key_valid  (key_valid),
        .key_repeat (key_repeat),
        .press_cnt  (press_cnt),
        .err        (err)
    );

    logic [7:0] fifo[$];
    logic [7:0] popped[$];
    logic [7:0] ev_code[$];
    logic       ev_ext[$];
    logic       ev_down[$];
    logic       ev_rep[$];
    int         pulses = 0;
    int         proto_err = 0;
    int         gap = 1000;
    int         total = 0;
    int         passed = 0;
    logic       prev_ready = 1'b0;
    logic       prev_low = 1'b0;

    // Keyboard FIFO model: head is popped at an edge where nextdata_n was low.
    always @(posedge clk) begin
        prev_ready = ready;
        if (nextdata_n === 1'b0 && fifo.size() != 0) popped.push_back(fifo.pop_front());
    end

    always @(negedge clk) begin
        if (nextdata_n === 1'b0) begin
            pulses++;
            if (prev_ready !== 1'b1) proto_err++;
            if (prev_low) proto_err++;
            if (gap < 2) proto_err++;
            gap = 0;
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
            if (gap < 1000) gap++;
        end
        if (key_valid === 1'b1) begin
            ev_code.push_back(key_code);
            ev_ext.push_back(key_ext);
            ev_down.push_back(key_down);
            ev_rep.push_back(key_repeat);
        end else if (key_repeat !== 1'b0) begin
            proto_err++;
        end
        #1;
        ready = (fifo.size() != 0);
        data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        fifo.push_back(b);
    endtask

    task automatic clear_log();
        ev_code.delete();
        ev_ext.delete();
        ev_down.delete();
        ev_rep.delete();
        popped.delete();
        pulses = 0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (fifo.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_budget", fifo.size(), 0);
        repeat (4) @(negedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] burst [5];
        int         bad;
        int         reps;
        logic       saw_low;
        burst = '{8'h15, 8'h24, 8'hF0, 8'h15, 8'h2D};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_nextdata_n", nextdata_n, 1);
        chk("rst_key", {key_code, key_ext, key_down, key_valid, key_repeat}, 0);
        chk("rst_press_cnt", press_cnt, 0);
        chk("rst_err", err, 0);
        clrn = 1'b1;

        // Single make
        clear_log();
        push(8'h1C);
        drain(40);
        chk("t1_pulses", pulses, 1);
        chk("t1_events", ev_code.size(), 1);
        chk("t1_event", {ev_code[0], ev_ext[0], ev_down[0], ev_rep[0]}, {8'h1C, 3'b010});
        chk("t1_press_cnt", press_cnt, 1);
        chk("t1_key_down", key_down, 1);
        chk("t1_valid_low", key_valid, 0);

        // Typematic repeats
        clear_log();
        push(8'h1C); push(8'h1C); push(8'h1C);
        drain(60);
        chk("t2_events", ev_code.size(), 3);
        chk("t2_repeat", {ev_rep[0], ev_rep[1], ev_rep[2]}, 3'b111);
        chk("t2_press_cnt", press_cnt, 1);
        chk("t2_pulses", pulses, 3);

        // Break, then fresh press
        clear_log();
        push(8'hF0); push(8'h1C);
        drain(40);
        chk("t3_events", ev_code.size(), 1);
        chk("t3_event", {ev_code[0], ev_ext[0], ev_down[0], ev_rep[0]}, {8'h1C, 3'b000});
        chk("t3_key_down", key_down, 0);
        chk("t3_press_cnt", press_cnt, 1);
        clear_log();
        push(8'h1C);
        drain(40);
        chk("t3_repress_cnt", press_cnt, 2);
        chk("t3_repress_rep", ev_rep[0], 0);

        // Extended make and break
        clear_log();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        drain(80);
        chk("t4_events", ev_code.size(), 2);
        chk("t4_make", {ev_code[0], ev_ext[0], ev_down[0], ev_rep[0]}, {8'h75, 3'b110});
        chk("t4_break", {ev_code[1], ev_ext[1], ev_down[1], ev_rep[1]}, {8'h75, 3'b100});
        chk("t4_press_cnt", press_cnt, 3);

        // Burst with ready held high
        clear_log();
        @(negedge clk);
        for (int i = 0; i < 5; i++) fifo.push_back(burst[i]);
        drain(80);
        chk("t5_pulses", pulses, 5);
        chk("t5_popped", popped.size(), 5);
        bad = 0;
        for (int i = 0; i < 5; i++) if (popped[i] !== burst[i]) bad++;
        chk("t5_order", bad, 0);
        chk("t5_events", ev_code.size(), 4);
        chk("t5_break", {ev_code[2], ev_down[2]}, {8'h15, 1'b0});
        chk("t5_press_cnt", press_cnt, 6);

        // Prefix inside a break sequence is ignored
        clear_log();
        push(8'hF0); push(8'hE0); push(8'h12);
        drain(60);
        chk("t5b_events", ev_code.size(), 1);
        chk("t5b_event", {ev_code[0], ev_ext[0], ev_down[0]}, {8'h12, 2'b00});
        chk("t5b_press_cnt", press_cnt, 6);

        // Counter wrap
        clear_log();
        for (int i = 0; i < 249; i++) push((i % 2) ? 8'h1C : 8'h1B);
        drain(1000);
        chk("wrap_events", ev_code.size(), 249);
        chk("wrap_255", press_cnt, 255);
        push(8'h1C);
        drain(40);
        chk("wrap_0", press_cnt, 0);
        reps = 0;
        foreach (ev_rep[i]) if (ev_rep[i] === 1'b1) reps++;
        chk("wrap_no_repeat", reps, 0);

        // Sticky error flag
        @(negedge clk); overflow = 1'b1;
        @(negedge clk); overflow = 1'b0;
        chk("err_set", err, 1);
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("err_clr", err, 0);
        @(negedge clk); overflow = 1'b1; clr_err = 1'b1;
        @(negedge clk); overflow = 1'b0; clr_err = 1'b0;
        chk("err_set_wins", err, 1);

        // Asynchronous reset while in ACK
        push(8'h1B);
        drain(40);
        chk("pre_rst_cnt", press_cnt, 1);
        push(8'h1C);
        saw_low = 1'b0;
        for (int i = 0; i < 20 && !saw_low; i++) begin
            @(negedge clk);
            #2;
            if (nextdata_n === 1'b0) saw_low = 1'b1;
        end
        chk("ack_reached", saw_low, 1);
        clrn = 1'b0;
        #1;
        chk("arst_nextdata_n", nextdata_n, 1);
        chk("arst_key", {key_code, key_ext, key_down, key_valid, key_repeat}, 0);
        chk("arst_cnt_err", {press_cnt, err}, 0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        drain(40);
        chk("protocol", proto_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
